// File: rtl/round_timer_ctrl.sv
// rtl/round_timer_ctrl.sv - two-digit BCD round countdown with prescaler, pause/resume and expiry
module round_timer_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int DIV_W    = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       paused,
  output logic       expired,
  output logic       dec_pulse,
  output logic       done_pulse
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_EXPIRED} state_t;

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);

  state_t           state_q, state_d;
  logic [3:0]       tens_q, ones_q, tens_d, ones_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             dec_q, dec_d, done_q, done_d;
  logic [3:0]       load_tens_c, load_ones_c;
  logic             advance;

  assign load_tens_c = (load_tens > 4'd9) ? 4'd9 : load_tens;
  assign load_ones_c = (load_ones > 4'd9) ? 4'd9 : load_ones;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      presc_q <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      presc_q <= presc_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    presc_d = presc_q;
    dec_d   = 1'b0;
    done_d  = 1'b0;
    advance = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
      presc_d = '0;
    end else if (start) begin
      tens_d  = load_tens_c;
      ones_d  = load_ones_c;
      presc_d = '0;
      if (load_tens_c == 4'd0 && load_ones_c == 4'd0) begin
        state_d = S_EXPIRED;
        done_d  = 1'b1;
      end else begin
        state_d = S_RUN;
      end
    end else begin
      // The resume edge itself counts, so a pause costs exactly its held cycles.
      case (state_q)
        S_RUN:   if (pause) state_d = S_PAUSE; else advance = 1'b1;
        S_PAUSE: if (pause) begin state_d = S_RUN; advance = 1'b1; end
        default: ;
      endcase
      if (advance) begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          dec_d   = 1'b1;
          if (ones_q != 4'd0) begin
            ones_d = ones_q - 4'd1;
          end else begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
          end
          if (tens_q == 4'd0 && ones_q == 4'd1) begin
            state_d = S_EXPIRED;
            done_d  = 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    running    = (state_q == S_RUN);
    paused     = (state_q == S_PAUSE);
    expired    = (state_q == S_EXPIRED);
    tens       = tens_q;
    ones       = ones_q;
    dec_pulse  = dec_q;
    done_pulse = done_q;
  end

endmodule
